gray_addr_encoder: RTL and testbench
====================================

Name: gray_addr_encoder

Overview:
- Request-side counterpart of the switch's one-hot address decoder.
- Takes 16 per-port request lines and selects one port per transaction, round-robin.
- Emits the selected port's 4-bit Gray-coded address, plus the matching one-hot grant, to the crossbar control path.
- Output uses a valid/ready handshake and is held stable until accepted.

Parameters:
- N_PORTS, 16, number of request lines (fixed at 16 for this switch; other values unsupported).
- ADDR_W, 4, width of the Gray-coded address (log2 N_PORTS).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  16  per-port request, level-sensitive; bit i = port i.
- addr_ready  input  1  downstream accepts addr this cycle.
- addr_gray  output  4  Gray-coded address of granted port.
- addr_valid  output  1  addr_gray and grant are valid.
- grant  output  16  one-hot grant; bit i set when port i is granted, else all zero.
- busy  output  1  high in HOLD state.

Behaviour:
- Gray coding: addr_gray = i ^ (i >> 1) for granted index i.
  - Mapping: 0->0000, 1->0001, 2->0011, 3->0010, 4->0110, 5->0111, 6->0101, 7->0100, 8->1100, 9->1101, 10->1111, 11->1110, 12->1010, 13->1011, 14->1001, 15->1000.
- Reset (async, immediate): addr_valid=0, addr_gray=0000, grant=0, busy=0, state=IDLE, priority pointer ptr=0.
- State IDLE:
  - If req==0: remain in IDLE, all outputs 0.
  - Otherwise, at the clock edge, select the first set bit at or after ptr, searching upward modulo 16.
  - Register addr_gray, grant and sel_idx; assert addr_valid; go to HOLD.
  - Latency: req sampled at edge N, addr_valid high after edge N.
- State HOLD:
  - addr_valid=1, busy=1; addr_gray and grant stay stable regardless of req changes.
  - A granted port dropping req does not cancel the transaction.
  - Handshake completes at an edge where addr_valid && addr_ready. At that edge:
    - ptr <= (sel_idx + 1) mod 16;
    - addr_valid, grant, busy <= 0; addr_gray <= 0000;
    - state <= IDLE.
  - One-cycle bubble is mandatory: a new arbitration occurs no earlier than the following edge.
- addr_ready while IDLE is ignored.
- Wrap-around: sel_idx=15 gives ptr=0.
- Single requester: the same port is re-granted every 2 cycles.
- Simultaneous requests: exactly one grant per transaction; grant always one-hot or zero.
- Reset asserted during HOLD: the transaction is dropped, and the downstream must treat it as never issued.
- req changing in the same cycle as the handshake does not affect the completing transaction.

Optional Feature:
- Macro: GRAY_ENC_RR_EN.
- Defined: round-robin selection with ptr exactly as above.
- Undefined: fixed priority, lowest set index wins. ptr logic is removed and its register is not synthesized. All other behaviour, timing and handshake are identical.

Decomposition:
- Shared package switch_pkg:
  - constants N_PORTS=16, ADDR_W=4;
  - typedefs port_vec_t [15:0] and port_addr_t [3:0];
  - functions bin2gray and gray2bin, reused by the decoder-side bench.
- One sub-module: rr_pick16. Combinational; inputs req and ptr; outputs found and sel_idx; contains the rotate / priority-encode / unrotate logic. The FSM and output registers live in gray_addr_encoder.

Test Plan:
- Reset, then req=0x0000 for 10 cycles -> addr_valid stays 0, grant=0, addr_gray=0000.
- req=0x0004, addr_ready=1 -> after 1 edge: addr_valid=1, addr_gray=0011, grant=0x0004. Cleared after the accept edge; regranted every 2 cycles.
- Round-robin (GRAY_ENC_RR_EN defined), req=0x8101 held, addr_ready=1 -> grant sequence 0x0001, 0x0100, 0x8000, 0x0001; addr_gray sequence 0000, 1100, 1000, 0000.
- Fixed priority (macro undefined), req=0x8101 held -> every grant is 0x0001 / 0000.
- Backpressure: grant port 10 (addr_gray=1111), hold addr_ready=0 for 5 cycles while req changes to 0x0002 -> addr_gray stays 1111, grant stays 0x0400. Next grant after the accept is port 1 (0001).
- Async rst pulsed mid-HOLD, between clock edges -> addr_valid, grant, addr_gray, busy go to 0 immediately. After release with req=0xFFFF, the first grant is port 0 (ptr reset).

Source files
------------

// File: rtl/switch_pkg.sv
// Shared switch definitions: port count, address width, port types and the
// Gray/binary conversion helpers used by the encoder and decoder sides.
package switch_pkg;

   localparam int N_PORTS = 16;
   localparam int ADDR_W  = 4;

   typedef logic [N_PORTS-1:0] port_vec_t;
   typedef logic [ADDR_W-1:0]  port_addr_t;

   // Binary index to reflected Gray code
   function automatic port_addr_t bin2gray(input port_addr_t b);
      return b ^ (b >> 1);
   endfunction

   // Reflected Gray code back to binary index (prefix XOR from the MSB)
   function automatic port_addr_t gray2bin(input port_addr_t g);
      port_addr_t b;
      b[ADDR_W-1] = g[ADDR_W-1];
      for (int i = ADDR_W-2; i >= 0; i--)
         b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

endpackage

// File: rtl/gray_addr_encoder_rr_pick16.sv
// rr_pick16: combinational round-robin picker. Rotates the request vector so
// that ptr lands at bit 0, priority-encodes the lowest set bit, then adds ptr
// back to recover the absolute port index (mod 16 by 4-bit wrap).
module rr_pick16
   import switch_pkg::*;
(
   input  logic [N_PORTS-1:0] req,
   input  logic [ADDR_W-1:0]  ptr,
   output logic               found,
   output logic [ADDR_W-1:0]  sel_idx
);

   logic [2*N_PORTS-1:0] dbl;
   logic [N_PORTS-1:0]   rot;
   port_addr_t           off;

   assign dbl = {req, req};
   assign rot = dbl[ptr +: N_PORTS];

   // Lowest set bit of the rotated vector is the first requester at/after ptr
   always_comb begin
      off = '0;
      for (int i = N_PORTS-1; i >= 0; i--)
         if (rot[i]) off = port_addr_t'(i);
   end

   assign sel_idx = ptr + off;
   assign found   = |req;

endmodule

// File: rtl/gray_addr_encoder.sv
// gray_addr_encoder: arbitrates 16 request lines, one port per transaction,
// and presents the winner's Gray address plus one-hot grant on a valid/ready
// output held stable until accepted. Every accept forces one idle cycle
// before the next arbitration.
// Build option: GRAY_ENC_RR_EN selects round-robin priority; without it the
// lowest requesting index always wins and no pointer register exists.
module gray_addr_encoder
   import switch_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [N_PORTS-1:0] req,
   input  logic               addr_ready,
   output logic [ADDR_W-1:0]  addr_gray,
   output logic               addr_valid,
   output logic [N_PORTS-1:0] grant,
   output logic               busy
);

   localparam logic S_IDLE = 1'b0;
   localparam logic S_HOLD = 1'b1;

   logic       state;
   logic       found;
   port_addr_t pick_idx;
   port_addr_t ptr;
   logic       accept;

   assign accept = (state == S_HOLD) && addr_ready;

`ifdef GRAY_ENC_RR_EN
   port_addr_t sel_q;

   // Remember the granted index and advance the pointer past it on accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q <= '0;
         ptr   <= '0;
      end else if (state == S_IDLE && found) begin
         sel_q <= pick_idx;
      end else if (accept) begin
         ptr   <= sel_q + 1'b1;
      end
   end
`else
   assign ptr = '0;
`endif

   rr_pick16 u_pick (
      .req     (req),
      .ptr     (ptr),
      .found   (found),
      .sel_idx (pick_idx)
   );

   // IDLE/HOLD control with registered outputs; reset drops any open transaction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         addr_valid <= 1'b0;
         busy       <= 1'b0;
         addr_gray  <= '0;
         grant      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (found) begin
                  state      <= S_HOLD;
                  addr_valid <= 1'b1;
                  busy       <= 1'b1;
                  addr_gray  <= bin2gray(pick_idx);
                  grant      <= {{(N_PORTS-1){1'b0}}, 1'b1} << pick_idx;
               end
            end
            default: begin
               if (accept) begin
                  state      <= S_IDLE;
                  addr_valid <= 1'b0;
                  busy       <= 1'b0;
                  addr_gray  <= '0;
                  grant      <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gray_addr_encoder.sv
// Bench for gray_addr_encoder: a transaction-level model (valid flag, granted
// index, priority pointer) is checked against the DUT after every clock edge
// and after reset, plus literal expectations from hand-worked scenarios.
module tb_gray_addr_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] req = '0;
   logic        addr_ready = 1'b0;
   logic [3:0]  addr_gray;
   logic        addr_valid;
   logic [15:0] grant;
   logic        busy;

   int checks = 0;
   int errors = 0;

   gray_addr_encoder dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .addr_ready (addr_ready),
      .addr_gray  (addr_gray),
      .addr_valid (addr_valid),
      .grant      (grant),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state
   bit m_valid;
   int m_idx;
   int m_ptr;

   function automatic logic [3:0] gray_of(input int i);
      return 4'((i ^ (i >> 1)) & 15);
   endfunction

   task automatic model_compare();
      logic [15:0] eg;
      logic [3:0]  ea;
      eg = m_valid ? 16'(1 << m_idx) : 16'h0;
      ea = m_valid ? gray_of(m_idx) : 4'h0;
      chk("m_valid", 32'(addr_valid), 32'(m_valid));
      chk("m_busy",  32'(busy),       32'(m_valid));
      chk("m_grant", 32'(grant),      32'(eg));
      chk("m_gray",  32'(addr_gray),  32'(ea));
   endtask

   // Model update and per-cycle comparison
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid = 0;
         m_idx   = 0;
         m_ptr   = 0;
         #1 model_compare();
      end else begin
         if (m_valid) begin
            if (addr_ready) begin
               m_valid = 0;
`ifdef GRAY_ENC_RR_EN
               m_ptr = (m_idx + 1) % 16;
`endif
            end
         end else if (req != 0) begin
            for (int k = 15; k >= 0; k--)
               if (req[(m_ptr + k) % 16]) m_idx = (m_ptr + k) % 16;
            m_valid = 1;
         end
         #1 model_compare();
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Wait (bounded) for a sample point with addr_valid high
   task automatic wait_valid(input string name, output bit ok);
      ok = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #2;
         if (addr_valid) begin
            ok = 1;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for addr_valid", name);
   endtask

   initial begin
      bit ok;
      logic [15:0] gseq [4];
      logic [3:0]  aseq [4];

      #1 rst = 1'b1;
      #2;
      chk("rst_valid", 32'(addr_valid), 0);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_gray",  32'(addr_gray), 0);
      chk("rst_busy",  32'(busy), 0);
      @(negedge clk);
      rst = 1'b0;

      // Idle: no requests, ready ignored
      addr_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #2;
         chk("idle_valid", 32'(addr_valid), 0);
      end
      chk("idle_grant", 32'(grant), 0);

      // Single requester port 2: latency one edge, regrant every 2 cycles
      @(negedge clk);
      req = 16'h0004;
      @(posedge clk);
      #2;
      chk("p2_valid", 32'(addr_valid), 1);
      chk("p2_gray",  32'(addr_gray), 32'b0011);
      chk("p2_grant", 32'(grant), 32'h0004);
      @(posedge clk);
      #2;
      chk("p2_bubble", 32'(addr_valid), 0);
      @(posedge clk);
      #2;
      chk("p2_regrant", 32'(grant), 32'h0004);

      // Multiple held requesters 0x8101
      do_reset();
      req = 16'h8101;
      addr_ready = 1'b1;
      for (int n = 0; n < 4; n++) begin
         wait_valid("seq", ok);
         gseq[n] = grant;
         aseq[n] = addr_gray;
      end
`ifdef GRAY_ENC_RR_EN
      chk("rr_g0", 32'(gseq[0]), 32'h0001);
      chk("rr_g1", 32'(gseq[1]), 32'h0100);
      chk("rr_g2", 32'(gseq[2]), 32'h8000);
      chk("rr_g3", 32'(gseq[3]), 32'h0001);
      chk("rr_a1", 32'(aseq[1]), 32'b1100);
      chk("rr_a2", 32'(aseq[2]), 32'b1000);
`else
      chk("fp_g1", 32'(gseq[1]), 32'h0001);
      chk("fp_g2", 32'(gseq[2]), 32'h0001);
      chk("fp_g3", 32'(gseq[3]), 32'h0001);
      chk("fp_a2", 32'(aseq[2]), 32'b0000);
`endif
      chk("seq_g0", 32'(gseq[0]), 32'h0001);
      chk("seq_a0", 32'(aseq[0]), 32'b0000);

      // Backpressure on port 10 while req changes
      do_reset();
      addr_ready = 1'b0;
      req = 16'h0400;
      wait_valid("bp", ok);
      @(negedge clk);
      req = 16'h0002;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #2;
         chk("bp_gray",  32'(addr_gray), 32'b1111);
         chk("bp_grant", 32'(grant), 32'h0400);
      end
      @(negedge clk);
      addr_ready = 1'b1;
      @(posedge clk);
      #2;
      chk("bp_accept", 32'(addr_valid), 0);
      wait_valid("bp_next", ok);
      chk("bp_next_gray", 32'(addr_gray), 32'b0001);
      chk("bp_next_grant", 32'(grant), 32'h0002);

      // Async reset mid-HOLD after moving the pointer
      @(negedge clk);
      addr_ready = 1'b0;
      req = 16'h0010;
      wait_valid("ar", ok);
      #1 rst = 1'b1;
      #1;
      chk("ar_valid", 32'(addr_valid), 0);
      chk("ar_grant", 32'(grant), 0);
      chk("ar_gray",  32'(addr_gray), 0);
      chk("ar_busy",  32'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      req = 16'hFFFF;
      addr_ready = 1'b1;
      wait_valid("ar_next", ok);
      chk("ar_first_grant", 32'(grant), 32'h0001);

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         case ($urandom_range(0, 3))
            0: req = 16'h0;
            1: req = 16'(1 << $urandom_range(0, 15));
            default: req = 16'($urandom);
         endcase
         addr_ready = ($urandom_range(0, 2) != 0);
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
